// File: rtl/p_addsub_pkg.sv
// Shared definitions for the multi-cycle packed add/subtract unit:
// FSM state encoding, pack-width decode and lane-start mask helpers.
package p_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Narrowest requested lane: the highest set bit j of pw selects xlen>>j.
  function automatic int pw_to_width(input logic [6:0] pw, input int xlen);
    int w;
    w = xlen;
    for (int j = 0; j < 7; j++) begin
      if (pw[j] && ((xlen >> j) >= 2)) w = xlen >> j;
    end
    return w;
  endfunction

  // One bit per lane start (i mod w == 0); w is always a power of two.
  function automatic logic [63:0] lane_mask(input int w, input int xlen);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i < xlen) && ((i & (w - 1)) == 0)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/p_addsub_slice.sv
// Combinational SLICE-bit ripple adder whose carry chain restarts with
// the subtract bit at every lane start marked in restart.
module p_addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  input  logic [SLICE-1:0] restart,
  input  logic             sub,
  output logic [SLICE-1:0] sum,
  output logic             c_out,
  output logic [SLICE-1:0] cin_bits,
  output logic [SLICE-1:0] cout_bits
);

  always_comb begin : p_chain
    logic c;
    c         = c_in;
    sum       = '0;
    cin_bits  = '0;
    cout_bits = '0;
    for (int i = 0; i < SLICE; i++) begin
      cin_bits[i]  = restart[i] ? sub : c;
      sum[i]       = a[i] ^ b[i] ^ cin_bits[i];
      cout_bits[i] = (a[i] & b[i]) | (cin_bits[i] & (a[i] ^ b[i]));
      c            = cout_bits[i];
    end
    c_out = c;
  end

endmodule

// File: rtl/p_addsub_mc.sv
// Multi-cycle packed add/subtract: SLICE bits per RUN cycle with a carry
// register between slices, then one FIX cycle for overflow and saturation.
module p_addsub_mc
  import p_addsub_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 8,
  parameter int PWW   = $clog2(XLEN)
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_lhs,
  input  logic [XLEN-1:0]   req_rhs,
  input  logic [PWW-1:0]    req_pw,
  input  logic              req_sub,
  input  logic              req_sat,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic [XLEN/2-1:0] rsp_ovf
);

  localparam int NSLICE = XLEN / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   lhs_reg, rhs_reg, mask_reg, result_reg, flip_reg;
  logic [PWW-1:0]    sel_reg;
  logic              sub_reg, sat_reg, carry_reg;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN/2-1:0] ovf_reg;

  int                width_in;
  logic [XLEN-1:0]   mask_in;
  logic [PWW-1:0]    sel_in;
  int                base;
  logic              last_slice;

  assign width_in   = pw_to_width(7'(req_pw), XLEN);
  assign mask_in    = XLEN'(lane_mask(width_in, XLEN));
  assign base       = int'(cnt_reg) * SLICE;
  assign last_slice = (cnt_reg == CW'(NSLICE - 1));

  for (genvar gi = 0; gi < PWW; gi++) begin : g_sel
    assign sel_in[gi] = (width_in == (XLEN >> gi));
  end

  logic [SLICE-1:0] s_sum, s_cin, s_cout;
  logic             s_carry;

  p_addsub_slice #(.SLICE(SLICE)) u_slice (
    .a         (lhs_reg[base +: SLICE]),
    .b         (rhs_reg[base +: SLICE]),
    .c_in      (carry_reg),
    .restart   (mask_reg[base +: SLICE]),
    .sub       (sub_reg),
    .sum       (s_sum),
    .c_out     (s_carry),
    .cin_bits  (s_cin),
    .cout_bits (s_cout)
  );

  // flip_reg holds carry-in ^ carry-out per bit; only lane MSBs matter.
  logic [XLEN-1:0] flip_msb;
  assign flip_msb = flip_reg & {1'b1, mask_reg[XLEN-1:1]};

  logic [PWW-1:0][XLEN-1:0]   res_all;
  logic [PWW-1:0][XLEN/2-1:0] ovf_all;

  for (genvar gj = 0; gj < PWW; gj++) begin : g_width
    localparam int W  = XLEN >> gj;
    localparam int NL = XLEN / W;
    for (genvar gk = 0; gk < XLEN/2; gk++) begin : g_lane
      if (gk < NL) begin : g_live
        assign ovf_all[gj][gk] = |flip_msb[gk*W +: W];
      end else begin : g_pad
        assign ovf_all[gj][gk] = 1'b0;
      end
    end
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
      localparam int MSB = (gi / W) * W + W - 1;
      logic clamp;
      assign clamp = sat_reg && ovf_all[gj][gi / W];
      // Clamp pattern: MSB copies the lhs sign, lower bits take its inverse.
      if (gi == MSB) begin : g_msb
        assign res_all[gj][gi] = clamp ? lhs_reg[MSB] : result_reg[gi];
      end else begin : g_low
        assign res_all[gj][gi] = clamp ? ~lhs_reg[MSB] : result_reg[gi];
      end
    end
  end

  logic [XLEN-1:0]   fix_result;
  logic [XLEN/2-1:0] fix_ovf;

  always_comb begin
    fix_result = result_reg;
    fix_ovf    = '0;
    for (int j = 0; j < PWW; j++) begin
      if (sel_reg[j]) begin
        fix_result = res_all[j];
        fix_ovf    = ovf_all[j];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = RUN;
      RUN:     if (last_slice) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lhs_reg    <= '0;
      rhs_reg    <= '0;
      mask_reg   <= '0;
      result_reg <= '0;
      flip_reg   <= '0;
      sel_reg    <= '0;
      sub_reg    <= 1'b0;
      sat_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      ovf_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lhs_reg   <= req_lhs;
            rhs_reg   <= req_rhs ^ {XLEN{req_sub}};
            mask_reg  <= mask_in;
            sel_reg   <= sel_in;
            sub_reg   <= req_sub;
            sat_reg   <= req_sat;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          result_reg[base +: SLICE] <= s_sum;
          flip_reg[base +: SLICE]   <= s_cin ^ s_cout;
          carry_reg                 <= s_carry;
          cnt_reg                   <= last_slice ? '0 : cnt_reg + 1'b1;
        end
        FIX: begin
          result_reg <= fix_result;
          ovf_reg    <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign rsp_valid  = (state_reg == DONE);
  assign rsp_result = result_reg;
  assign rsp_ovf    = ovf_reg;

endmodule

// File: tb/tb_p_addsub_mc.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized ops on four configurations against a lane-level arithmetic model.
module tb_p_addsub_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: XLEN=32, SLICE=8
  logic        rst, req_valid, req_ready, req_sub, req_sat, rsp_valid, rsp_ready;
  logic [31:0] req_lhs, req_rhs, rsp_result;
  logic [4:0]  req_pw;
  logic [15:0] rsp_ovf;

  p_addsub_mc #(.XLEN(32), .SLICE(8)) u_dut (
    .g_clk(clk), .g_reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_pw(req_pw), .req_sub(req_sub),
    .req_sat(req_sat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf));

  // Extra configurations share one request stream and always accept responses.
  logic        x_rst, x_valid, x_sub, x_sat;
  logic [63:0] x_lhs, x_rhs;
  logic [5:0]  x_pw;
  logic        e1_ready, e1_valid, e2_ready, e2_valid, e3_ready, e3_valid;
  logic [31:0] e1_result, e2_result;
  logic [63:0] e3_result;
  logic [15:0] e1_ovf, e2_ovf;
  logic [31:0] e3_ovf;

  p_addsub_mc #(.XLEN(32), .SLICE(1)) u_e1 (
    .g_clk(clk), .g_reset(x_rst), .req_valid(x_valid), .req_ready(e1_ready),
    .req_lhs(x_lhs[31:0]), .req_rhs(x_rhs[31:0]), .req_pw(x_pw[4:0]), .req_sub(x_sub),
    .req_sat(x_sat), .rsp_valid(e1_valid), .rsp_ready(1'b1),
    .rsp_result(e1_result), .rsp_ovf(e1_ovf));

  p_addsub_mc #(.XLEN(32), .SLICE(32)) u_e2 (
    .g_clk(clk), .g_reset(x_rst), .req_valid(x_valid), .req_ready(e2_ready),
    .req_lhs(x_lhs[31:0]), .req_rhs(x_rhs[31:0]), .req_pw(x_pw[4:0]), .req_sub(x_sub),
    .req_sat(x_sat), .rsp_valid(e2_valid), .rsp_ready(1'b1),
    .rsp_result(e2_result), .rsp_ovf(e2_ovf));

  p_addsub_mc #(.XLEN(64), .SLICE(8)) u_e3 (
    .g_clk(clk), .g_reset(x_rst), .req_valid(x_valid), .req_ready(e3_ready),
    .req_lhs(x_lhs), .req_rhs(x_rhs), .req_pw(x_pw), .req_sub(x_sub),
    .req_sat(x_sat), .rsp_valid(e3_valid), .rsp_ready(1'b1),
    .rsp_result(e3_result), .rsp_ovf(e3_ovf));

  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    bit          sub;
    bit          sat;
    logic [31:0] res;
    logic [15:0] ovf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // Reference: each lane as a signed integer, exact sum/difference, then
  // range check against the lane's signed limits.
  function automatic void model(input int xlen, input logic [63:0] lhs, input logic [63:0] rhs,
                                input logic [6:0] pw, input bit sub, input bit sat,
                                output logic [63:0] res, output logic [31:0] ovf);
    int w;
    logic signed [65:0] a, b, r, mx, mn;
    w = xlen;
    for (int j = 0; j < 7; j++) if (pw[j] && (xlen >> j) >= 2) w = xlen >> j;
    res = '0;
    ovf = '0;
    for (int k = 0; k < xlen / w; k++) begin
      a = '0;
      b = '0;
      for (int i = 0; i < w; i++) begin
        a[i] = lhs[k*w + i];
        b[i] = rhs[k*w + i];
      end
      for (int i = w; i < 66; i++) begin
        a[i] = a[w-1];
        b[i] = b[w-1];
      end
      r  = sub ? a - b : a + b;
      mx = (66'sd1 <<< (w - 1)) - 66'sd1;
      mn = -(66'sd1 <<< (w - 1));
      if (r > mx || r < mn) begin
        ovf[k] = 1'b1;
        if (sat) r = (r > mx) ? mx : mn;
      end
      for (int i = 0; i < w; i++) res[k*w + i] = r[i];
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge with the main unit idle; returns at the negedge after accept.
  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [4:0] pw,
                      input bit sb, input bit st);
    req_valid = 1'b1;
    req_lhs = l; req_rhs = r; req_pw = pw; req_sub = sb; req_sat = st;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_lhs = $urandom; req_rhs = $urandom;
    req_pw = 5'($urandom_range(0, 31)); req_sub = 1'($urandom); req_sat = 1'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got=no_valid expected=valid within 100 cycles");
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic main_op(input string tag, input logic [31:0] l, input logic [31:0] r,
                         input logic [4:0] pw, input bit sb, input bit st,
                         input logic [31:0] eres, input logic [15:0] eovf);
    int lat;
    send(l, r, pw, sb, st);
    wait_rsp(lat);
    $display("%s lhs=%h rhs=%h pw=%b sub=%0d sat=%0d -> res=%h ovf=%h lat=%0d",
             tag, l, r, pw, sb, st, rsp_result, rsp_ovf, lat);
    check({tag, "_res"}, 64'(rsp_result), 64'(eres));
    check({tag, "_ovf"}, 64'(rsp_ovf), 64'(eovf));
    check({tag, "_lat"}, 64'(lat), 64'd5);
    ack();
  endtask

  task automatic ext_op(input logic [63:0] l, input logic [63:0] r, input logic [5:0] pw,
                        input bit sb, input bit st);
    bit [2:0]    seen;
    int          lat, lat1, lat2, lat3;
    logic [31:0] res1, res2;
    logic [63:0] res3, m_res;
    logic [15:0] ovf1, ovf2;
    logic [31:0] ovf3, m_ovf;
    seen = '0; lat1 = 0; lat2 = 0; lat3 = 0;
    res1 = '0; res2 = '0; res3 = '0; ovf1 = '0; ovf2 = '0; ovf3 = '0;
    x_valid = 1'b1; x_lhs = l; x_rhs = r; x_pw = pw; x_sub = sb; x_sat = st;
    @(posedge clk);
    @(negedge clk);
    x_valid = 1'b0;
    x_lhs = {$urandom, $urandom}; x_rhs = {$urandom, $urandom}; x_pw = 6'($urandom);
    lat = 0;
    while (seen != 3'b111 && lat < 60) begin
      if (!seen[0] && e1_valid) begin seen[0] = 1'b1; lat1 = lat; res1 = e1_result; ovf1 = e1_ovf; end
      if (!seen[1] && e2_valid) begin seen[1] = 1'b1; lat2 = lat; res2 = e2_result; ovf2 = e2_ovf; end
      if (!seen[2] && e3_valid) begin seen[2] = 1'b1; lat3 = lat; res3 = e3_result; ovf3 = e3_ovf; end
      if (seen != 3'b111) begin
        @(negedge clk);
        lat++;
      end
    end
    @(negedge clk);
    $display("ext lhs=%h rhs=%h pw=%b sub=%0d sat=%0d -> s1=%h s32=%h x64=%h",
             l, r, pw, sb, st, res1, res2, res3);
    check("ext_seen", 64'(seen), 64'(3'b111));
    model(32, {32'b0, l[31:0]}, {32'b0, r[31:0]}, 7'(pw[4:0]), sb, st, m_res, m_ovf);
    check("s1_res", 64'(res1), 64'(m_res[31:0]));
    check("s1_ovf", 64'(ovf1), 64'(m_ovf[15:0]));
    check("s1_lat", 64'(lat1), 64'd33);
    check("s32_res", 64'(res2), 64'(m_res[31:0]));
    check("s32_ovf", 64'(ovf2), 64'(m_ovf[15:0]));
    check("s32_lat", 64'(lat2), 64'd2);
    model(64, l, r, 7'(pw), sb, st, m_res, m_ovf);
    check("x64_res", res3, m_res);
    check("x64_ovf", 64'(ovf3), 64'(m_ovf));
    check("x64_lat", 64'(lat3), 64'd9);
  endtask

  initial begin
    logic [31:0] r0, l, r;
    logic [15:0] o0;
    logic [63:0] m_res;
    logic [31:0] m_ovf;
    logic [4:0]  pw;
    bit          sb, st, seen_valid;
    int          lat;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 5'b00001, 1'b0, 1'b0, 32'h00000000, 16'h0000};
    vecs[1]  = '{32'h00010203, 32'h01010101, 5'b00100, 1'b1, 1'b0, 32'hFF000102, 16'h0000};
    vecs[2]  = '{32'h7FFF0001, 32'h00010001, 5'b00010, 1'b0, 1'b1, 32'h7FFF0002, 16'h0002};
    vecs[3]  = '{32'h7FFF0001, 32'h00010001, 5'b00010, 1'b0, 1'b0, 32'h80000002, 16'h0002};
    vecs[4]  = '{32'h00000000, 32'h55555555, 5'b10000, 1'b1, 1'b1, 32'hFFFFFFFF, 16'h0000};
    vecs[5]  = '{32'hAAAAAAAA, 32'h55555555, 5'b10000, 1'b1, 1'b1, 32'hAAAAAAAA, 16'hFFFF};
    vecs[6]  = '{32'h7F7F7F7F, 32'h01010101, 5'b00101, 1'b0, 1'b0, 32'h80808080, 16'h000F};
    vecs[7]  = '{32'h7FFFFFFF, 32'h00000001, 5'b00000, 1'b0, 1'b1, 32'h7FFFFFFF, 16'h0001};
    vecs[8]  = '{32'h80000000, 32'h00000001, 5'b00001, 1'b1, 1'b0, 32'h7FFFFFFF, 16'h0001};
    vecs[9]  = '{32'h88888888, 32'h88888888, 5'b01000, 1'b0, 1'b1, 32'h88888888, 16'h00FF};
    vecs[10] = '{32'h88888888, 32'h88888888, 5'b01000, 1'b0, 1'b0, 32'h00000000, 16'h00FF};
    vecs[11] = '{32'h80808080, 32'h01010101, 5'b00100, 1'b1, 1'b1, 32'h80808080, 16'h000F};

    rst = 1'b1; req_valid = 1'b0; req_lhs = '0; req_rhs = '0; req_pw = '0;
    req_sub = 1'b0; req_sat = 1'b0; rsp_ready = 1'b0;
    x_rst = 1'b1; x_valid = 1'b0; x_lhs = '0; x_rhs = '0; x_pw = '0; x_sub = 1'b0; x_sat = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_ovf", 64'(rsp_ovf), 64'd0);
    rst = 1'b0;
    x_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++)
      main_op($sformatf("vec%0d", i), vecs[i].lhs, vecs[i].rhs, vecs[i].pw,
              vecs[i].sub, vecs[i].sat, vecs[i].res, vecs[i].ovf);

    // Backpressure: hold DONE three cycles while offering a competing request.
    send(32'h7FFF0001, 32'h00010001, 5'b00010, 1'b0, 1'b1);
    wait_rsp(lat);
    r0 = rsp_result;
    o0 = rsp_ovf;
    check("bp_res", 64'(r0), 64'h7FFF0002);
    check("bp_ovf", 64'(o0), 64'h0002);
    req_valid = 1'b1; req_lhs = 32'h12345678; req_rhs = 32'h11111111; req_pw = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $display("bp cycle %0d res=%h ovf=%h valid=%0d ready=%0d", c, rsp_result, rsp_ovf, rsp_valid, req_ready);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_hold_res", 64'(rsp_result), 64'(r0));
      check("bp_hold_ovf", 64'(rsp_ovf), 64'(o0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_no_accept", 64'(req_ready), 64'd1);

    // Reset while slice 2 is in flight: everything returns to reset values.
    send(32'hFFFFFFFF, 32'h00000001, 5'b00001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    $display("reset-abort seen_valid=%0d ready=%0d", seen_valid, req_ready);
    check("mid_rst_no_rsp", 64'(seen_valid), 64'd0);
    check("mid_rst_idle", 64'(req_ready), 64'd1);
    main_op("post_rst", vecs[1].lhs, vecs[1].rhs, vecs[1].pw, vecs[1].sub, vecs[1].sat,
            vecs[1].res, vecs[1].ovf);

    for (int n = 0; n < 100; n++) begin
      l  = $urandom;
      r  = $urandom;
      pw = 5'($urandom_range(0, 31));
      sb = 1'($urandom);
      st = 1'($urandom);
      model(32, {32'b0, l}, {32'b0, r}, 7'(pw), sb, st, m_res, m_ovf);
      main_op($sformatf("rnd%0d", n), l, r, pw, sb, st, m_res[31:0], m_ovf[15:0]);
    end

    for (int i = 0; i < NVEC; i++)
      ext_op({vecs[i].lhs, vecs[i].lhs}, {vecs[i].rhs, vecs[i].rhs}, 6'(vecs[i].pw),
             vecs[i].sub, vecs[i].sat);
    for (int n = 0; n < 30; n++)
      ext_op({$urandom, $urandom}, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
             1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
